alu_seq: RTL and testbench

Registered, parametrised ALU that replaces the purely combinational datapath ALU. One operation is accepted per `start` pulse. Single-cycle logic and arithmetic ops complete in one clock; shifts and the optional multiply run iteratively under a small FSM. Result and a four-bit flag set (carry, zero, negative, overflow) are held in registers and driven onto the shared tristate data bus when `enable` is high.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_iter.sv | 160 ++++++++++++++++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag
// vector layout and signed-overflow helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SAR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } alu_state_t;

  // Bit positions inside the registered flag vector.
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int FLG_W = 4;

  // Signed overflow of a+b given operand and result sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a-b given operand and result sign bits.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative engine for shifts (one bit per cycle) and, when ALU_MUL_EN is
// defined, an unsigned shift-add multiplier. The final step is presented
// combinationally on res/carry together with fin so the parent can write
// its result register on the same edge the engine returns to IDLE.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
`ifdef ALU_MUL_EN
  input  logic [WIDTH-1:0] b,
`endif
  input  logic [SHW-1:0]   k,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  localparam int             CW      = SHW + 1;
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
`ifdef ALU_MUL_EN
  localparam logic [CW-1:0]  CNT_MUL = CW'(WIDTH);
`endif

  alu_state_t       state_r;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic [WIDTH-1:0] step_lo_s;
  logic             step_c_s;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH:0]   sum_s;
`endif

  // Next value of the working registers for one iteration step.
  always_comb begin
    step_lo_s = lo_r;
    step_c_s  = 1'b0;
`ifdef ALU_MUL_EN
    step_hi_s = hi_r;
    sum_s     = {(WIDTH+1){1'b0}};
`endif
    case (state_r)
      ST_SHIFT: begin
        case (op_r)
          OP_SHL: begin
            step_lo_s = {lo_r[WIDTH-2:0], 1'b0};
            step_c_s  = lo_r[WIDTH-1];
          end
          OP_SHR: begin
            step_lo_s = {1'b0, lo_r[WIDTH-1:1]};
            step_c_s  = lo_r[0];
          end
          OP_SAR: begin
            step_lo_s = {lo_r[WIDTH-1], lo_r[WIDTH-1:1]};
            step_c_s  = lo_r[0];
          end
          default: begin
            step_lo_s = lo_r;
            step_c_s  = 1'b0;
          end
        endcase
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        // Right-shifting multiplier: {hi,lo} holds the full product at the end.
        sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        step_hi_s = sum_s[WIDTH:1];
        step_lo_s = {sum_s[0], lo_r[WIDTH-1:1]};
        step_c_s  = |sum_s[WIDTH:1];
      end
`endif
      default: begin
        step_lo_s = lo_r;
        step_c_s  = 1'b0;
      end
    endcase
  end

  // Engine FSM: load on go, iterate until the counter reaches one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      op_r    <= OP_ADD;
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
`ifdef ALU_MUL_EN
      hi_r    <= {WIDTH{1'b0}};
      mcand_r <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go) begin
            op_r   <= op;
            busy_r <= 1'b1;
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
              mcand_r <= a;
              lo_r    <= b;
              hi_r    <= {WIDTH{1'b0}};
              cnt_r   <= CNT_MUL;
              state_r <= ST_MUL;
            end else begin
              lo_r    <= a;
              cnt_r   <= {1'b0, k};
              state_r <= ST_SHIFT;
            end
`else
            lo_r    <= a;
            cnt_r   <= {1'b0, k};
            state_r <= ST_SHIFT;
`endif
          end
        end
        ST_SHIFT: begin
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          lo_r  <= step_lo_s;
          hi_r  <= step_hi_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign fin   = (state_r != ST_IDLE) && (cnt_r == CNT_ONE);
  assign res   = step_lo_s;
  assign carry = step_c_s;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with carry/zero/negative/overflow flags and a tristate
// result bus. Single-cycle ops write the registers on the accepting edge;
// shifts with k>0 (and multiply when ALU_MUL_EN is defined) run in alu_iter.
// Without ALU_MUL_EN, opcode 11 behaves like any invalid opcode.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [3:0]       select,
  input  logic             start,
  input  logic             enable,
  output logic             busy,
  output logic             done,
  output tri   [WIDTH-1:0] bus,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag
);

  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [SHW-1:0]   k_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] dp_res_s;
  logic             dp_c_s;
  logic             dp_v_s;
  logic             dp_valid_s;
  logic             dp_iter_s;
  logic             accept_s;
  logic             go_s;
  logic             busy_s;
  logic             fin_s;
  logic [WIDTH-1:0] it_res_s;
  logic             it_c_s;
  logic             wb_en_s;
  logic [WIDTH-1:0] wb_res_s;
  logic             wb_c_s;
  logic             wb_v_s;
  logic             done_s;
  logic [WIDTH-1:0] result_r;
  logic [FLG_W-1:0] flags_r;
  logic             done_r;

  assign k_s = in_2[SHW-1:0];

  // Single-cycle datapath and opcode classification.
  always_comb begin
    sum_s      = {(WIDTH+1){1'b0}};
    dp_res_s   = {WIDTH{1'b0}};
    dp_c_s     = 1'b0;
    dp_v_s     = 1'b0;
    dp_valid_s = 1'b1;
    dp_iter_s  = 1'b0;
    case (select)
      OP_ADD: begin
        sum_s    = {1'b0, in_1} + {1'b0, in_2};
        dp_res_s = sum_s[WIDTH-1:0];
        dp_c_s   = sum_s[WIDTH];
        dp_v_s   = add_ovf(in_1[WIDTH-1], in_2[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        sum_s    = {1'b0, in_1} - {1'b0, in_2};
        dp_res_s = sum_s[WIDTH-1:0];
        dp_c_s   = sum_s[WIDTH];
        dp_v_s   = sub_ovf(in_1[WIDTH-1], in_2[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_AND: dp_res_s = in_1 & in_2;
      OP_OR:  dp_res_s = in_1 | in_2;
      OP_XOR: dp_res_s = in_1 ^ in_2;
      OP_NOT: dp_res_s = ~in_1;
      OP_INC: begin
        sum_s    = {1'b0, in_1} + ONE_EXT;
        dp_res_s = sum_s[WIDTH-1:0];
        dp_c_s   = sum_s[WIDTH];
        dp_v_s   = add_ovf(in_1[WIDTH-1], 1'b0, sum_s[WIDTH-1]);
      end
      OP_DEC: begin
        sum_s    = {1'b0, in_1} - ONE_EXT;
        dp_res_s = sum_s[WIDTH-1:0];
        dp_c_s   = sum_s[WIDTH];
        dp_v_s   = sub_ovf(in_1[WIDTH-1], 1'b0, sum_s[WIDTH-1]);
      end
      OP_SHL, OP_SHR, OP_SAR: begin
        // A zero-distance shift completes immediately with carry clear.
        dp_res_s  = in_1;
        dp_iter_s = (k_s != {SHW{1'b0}});
      end
`ifdef ALU_MUL_EN
      OP_MUL: dp_iter_s = 1'b1;
`endif
      default: dp_valid_s = 1'b0;
    endcase
  end

  assign accept_s = start && !busy_s;
  assign go_s     = accept_s && dp_iter_s;

  alu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go_s),
    .op    (select),
    .a     (in_1),
`ifdef ALU_MUL_EN
    .b     (in_2),
`endif
    .k     (k_s),
    .busy  (busy_s),
    .fin   (fin_s),
    .res   (it_res_s),
    .carry (it_c_s)
  );

  // Select the write-back source: finishing engine or immediate op.
  always_comb begin
    wb_res_s = dp_res_s;
    wb_c_s   = dp_c_s;
    wb_v_s   = dp_v_s;
    wb_en_s  = 1'b0;
    if (fin_s) begin
      wb_en_s  = 1'b1;
      wb_res_s = it_res_s;
      wb_c_s   = it_c_s;
      wb_v_s   = 1'b0;
    end else if (accept_s && !dp_iter_s && dp_valid_s) begin
      wb_en_s = 1'b1;
    end else begin
      wb_en_s = 1'b0;
    end
  end

  assign done_s = fin_s || (accept_s && !dp_iter_s);

  // Result, flag and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= {WIDTH{1'b0}};
      flags_r  <= {FLG_W{1'b0}};
      done_r   <= 1'b0;
    end else begin
      done_r <= done_s;
      if (wb_en_s) begin
        result_r       <= wb_res_s;
        flags_r[FLG_C] <= wb_c_s;
        flags_r[FLG_Z] <= (wb_res_s == {WIDTH{1'b0}});
        flags_r[FLG_N] <= wb_res_s[WIDTH-1];
        flags_r[FLG_V] <= wb_v_s;
      end
    end
  end

  assign busy      = busy_s;
  assign done      = done_r;
  assign carry_out = flags_r[FLG_C];
  assign zero_flag = flags_r[FLG_Z];
  assign neg_flag  = flags_r[FLG_N];
  assign ovf_flag  = flags_r[FLG_V];
  assign bus       = enable ? result_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16). Stimulus pushes hand-computed
// expectations; a monitor pops and compares whenever done pulses.
`timescale 1ns/1ps
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_1 = 16'h0000;
  logic [15:0] in_2 = 16'h0000;
  logic [3:0]  select = 4'd0;
  logic        start = 1'b0;
  logic        enable = 1'b1;
  logic        busy, done, carry_out, zero_flag, neg_flag, ovf_flag;
  wire  [15:0] bus_w;

  // Weak pull so an undriven bus reads as all ones.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup (bus_w[gi]);
  end

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_1(in_1), .in_2(in_2), .select(select),
    .start(start), .enable(enable), .busy(busy), .done(done), .bus(bus_w),
    .carry_out(carry_out), .zero_flag(zero_flag), .neg_flag(neg_flag),
    .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [3:0]  flg;   // {carry, zero, neg, ovf}
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_cycles = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: count busy cycles and score every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && busy) busy_cycles++;
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_res"}, {16'h0000, bus_w}, {16'h0000, e.res});
          chk({e.name, "_flags"}, {28'h0, carry_out, zero_flag, neg_flag, ovf_flag}, {28'h0, e.flg});
          chk({e.name, "_done_cycle"}, cyc, e.due);
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] res, input logic [3:0] flg,
                       input int iter, input bit wait_it);
    exp_t e;
    @(negedge clk);
    in_1 = a;
    in_2 = b;
    select = op;
    start = 1'b1;
    busy_cycles = 0;
    e.name = nm;
    e.res = res;
    e.flg = flg;
    e.due = cyc + 1 + iter;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    if (wait_it) begin
      wait_idle(nm);
      chk({nm, "_busy_cycles"}, busy_cycles, iter);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", {16'h0000, bus_w}, 32'h0);
    chk("rst_flags", {28'h0, carry_out, zero_flag, neg_flag, ovf_flag}, 32'h0);
    chk("rst_busy_done", {30'h0, busy, done}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    //    name          op      in_1      in_2      result    {c,z,n,v} iter
    issue("add_ffff_1", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 0, 1'b1);
    issue("or_1_0",     OP_OR,  16'h0001, 16'h0000, 16'h0001, 4'b0000, 0, 1'b1);
    issue("sub_8000_1", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 0, 1'b1);
    issue("sub_1_2",    OP_SUB, 16'h0001, 16'h0002, 16'hFFFF, 4'b1010, 0, 1'b1);
    issue("and",        OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 0, 1'b1);
    issue("xor_self",   OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100, 0, 1'b1);
    issue("not",        OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 4'b0010, 0, 1'b1);
    issue("inc_7fff",   OP_INC, 16'h7FFF, 16'h0000, 16'h8000, 4'b0011, 0, 1'b1);
    issue("dec_0",      OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 4'b1010, 0, 1'b1);
    issue("add_7fff_1", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 0, 1'b1);

    // sar with an ignored start and an enable toggle while busy.
    issue("sar_8001_4", OP_SAR, 16'h8001, 16'h0004, 16'hF800, 4'b0010, 4, 1'b0);
    @(negedge clk);
    chk("sar_busy_mid", {31'h0, busy}, 32'h1);
    in_1 = 16'h1234;
    in_2 = 16'h0001;
    select = OP_ADD;
    start = 1'b1;
    enable = 1'b0;
    #1 chk("bus_released", {16'h0000, bus_w}, 32'h0000FFFF);
    @(posedge clk);
    #1 start = 1'b0;
    chk("sar_busy_after_toggle", {31'h0, busy}, 32'h1);
    @(negedge clk);
    enable = 1'b1;
    #1 chk("bus_holds_old_result", {16'h0000, bus_w}, 32'h00008000);
    wait_idle("sar_8001_4");
    chk("sar_8001_4_busy_cycles", busy_cycles, 4);

    issue("shl_8001_0",  OP_SHL, 16'h8001, 16'h0000, 16'h8001, 4'b0010, 0, 1'b1);
    issue("shr_3_1",     OP_SHR, 16'h0003, 16'h0001, 16'h0001, 4'b1000, 1, 1'b1);
    issue("shl_8001_1",  OP_SHL, 16'h8001, 16'h0001, 16'h0002, 4'b1000, 1, 1'b1);
    issue("shl_1_15",    OP_SHL, 16'h0001, 16'h000F, 16'h8000, 4'b0010, 15, 1'b1);
    issue("invalid_12",  4'd12,  16'h1111, 16'h2222, 16'h8000, 4'b0010, 0, 1'b1);
`ifdef ALU_MUL_EN
    issue("mul_100_100", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1100, 16, 1'b1);
    issue("mul_3_5",     OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 16, 1'b1);
    issue("mul_ffff_sq", OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b1000, 16, 1'b1);
`else
    issue("invalid_11",  OP_MUL, 16'h0003, 16'h0005, 16'h8000, 4'b0010, 0, 1'b1);
`endif

    // Reset in the middle of a long iterative op: no done, outputs cleared.
    @(negedge clk);
    in_1 = 16'h0001;
`ifdef ALU_MUL_EN
    in_2 = 16'h0100;
    select = OP_MUL;
`else
    in_2 = 16'h000F;
    select = OP_SHL;
`endif
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before_reset", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_bus", {16'h0000, bus_w}, 32'h0);
    chk("abort_flags", {28'h0, carry_out, zero_flag, neg_flag, ovf_flag}, 32'h0);
    chk("abort_busy_done", {30'h0, busy, done}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue("add_after_rst", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 0, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
